systolic_tile_sequencer: RTL and testbench

//  Parametrised top-level sequencer for the systolic array. It walks NUM_TILES
//  row tiles through the load phase and then issues the layer phase, repeating

---
 rtl/systolic_tile_sequencer_pkg.sv | 32 +++
 rtl/systolic_tile_sequencer_valid_token_pipe.sv | 51 +++++
 rtl/systolic_tile_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_systolic_tile_sequencer.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_tile_sequencer_pkg.sv
// Shared definitions for the systolic tile sequencer: mode encodings,
// FSM state enumeration and width helpers for counters and indices.
package seq_pkg;

   localparam logic [2:0] MODE_IDLE  = 3'd0;
   localparam logic [2:0] MODE_LOAD  = 3'd1;
   localparam logic [2:0] MODE_LAYER = 3'd2;

   typedef enum logic [3:0] {
      IDLE,
      ISSUE_LOAD,
      WAIT_LOAD,
      NEXT_TILE,
      ISSUE_LAYER,
      WAIT_LAY_ON,
      WAIT_LAY_OFF,
      NEXT_LAYER,
      DONE,
      ERR
   } seq_state_t;

   // Width of an index selecting one of n items (never narrower than 1 bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter that must hold the value max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/systolic_tile_sequencer_valid_token_pipe.sv
// Load-phase valid token pipeline. A load arms TOK_LEN tokens; each cycle
// with advance high and tokens remaining injects a '1' into tap 0. All
// taps shift toward the last MAC column every cycle, independent of advance.
module valid_token_pipe
   import seq_pkg::*;
#(
   parameter int PIPE_DEPTH = 4,
   parameter int TOK_LEN    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  advance,
   input  logic                  clear,
   output logic [PIPE_DEPTH-1:0] taps,
   output logic                  empty
);

   localparam int CW = cnt_width(TOK_LEN);

   logic [CW-1:0]         tok_cnt;
   logic                  inject;
   logic [PIPE_DEPTH-1:0] taps_next;

   // Decide whether a token enters tap 0 and form the shifted tap vector.
   always_comb begin
      inject       = advance && (tok_cnt != '0) && !load;
      taps_next    = taps << 1;
      taps_next[0] = inject;
   end

   // Token budget and tap shift register; clear flushes everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tok_cnt <= '0;
         taps    <= '0;
      end else if (clear) begin
         tok_cnt <= '0;
         taps    <= '0;
      end else begin
         taps <= taps_next;
         if (load)
            tok_cnt <= CW'(TOK_LEN);
         else if (inject)
            tok_cnt <= tok_cnt - 1'b1;
      end
   end

   assign empty = (tok_cnt == '0) && (taps == '0);

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Top-level sequencer: walks NUM_TILES row tiles through the load phase,
// then issues one layer pass, repeated NUM_LAYERS times per start.
// Optional watchdog enabled by defining SEQ_TIMEOUT_EN.
// All outputs are registered from the next-state decode, so each pulse is
// visible during the cycle the FSM occupies the corresponding state.
module systolic_tile_sequencer
   import seq_pkg::*;
#(
   parameter int N          = 8,
   parameter int TILE       = 4,
   parameter int NUM_LAYERS = 2,
   parameter int PIPE_DEPTH = 4,
   parameter int TOK_LEN    = 2,
   parameter int TMO_CYC    = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              abort,
   input  logic                              load_ready,
   input  logic                              layer_busy,
   output logic [2:0]                        mode,
   output logic                              start_load,
   output logic                              start_layer,
   output logic                              next_tile,
   output logic [idx_width(N/TILE)-1:0]      tile_idx,
   output logic [idx_width(NUM_LAYERS)-1:0]  layer_idx,
   output logic [PIPE_DEPTH-1:0]             valid_ctrl,
   output logic                              busy,
   output logic                              done,
   output logic                              err
);

   localparam int NUM_TILES = N / TILE;
   localparam int TW        = idx_width(NUM_TILES);
   localparam int LW        = idx_width(NUM_LAYERS);

   if (((N % TILE) != 0) || (TMO_CYC < 1)) begin : g_cfg_check
      $error("systolic_tile_sequencer: N must be a multiple of TILE and TMO_CYC >= 1");
   end

   seq_state_t state;
   seq_state_t state_next;
   logic [2:0] mode_next;
   logic       accept;
   logic       abort_hit;
   logic       pipe_load;
   logic       pipe_empty;
   logic       tile_last;
   logic       layer_last;
   logic       tile_inc;
   logic       layer_inc;

   assign abort_hit  = abort && (state != IDLE);
   assign tile_last  = (tile_idx == TW'(NUM_TILES - 1));
   assign layer_last = (layer_idx == LW'(NUM_LAYERS - 1));

`ifdef SEQ_TIMEOUT_EN
   localparam int WD_W = cnt_width(TMO_CYC);
   logic [WD_W-1:0] wd;
   logic            in_wait;
   logic            wd_expired;

   assign in_wait    = (state == WAIT_LOAD) || (state == WAIT_LAY_ON) || (state == WAIT_LAY_OFF);
   assign wd_expired = in_wait && (wd == WD_W'(TMO_CYC - 1));
`endif

   valid_token_pipe #(
      .PIPE_DEPTH (PIPE_DEPTH),
      .TOK_LEN    (TOK_LEN)
   ) u_pipe (
      .clk     (clk),
      .rst     (rst),
      .load    (pipe_load),
      .advance (load_ready),
      .clear   (abort_hit),
      .taps    (valid_ctrl),
      .empty   (pipe_empty)
   );

   // Next-state logic with counter strobes; abort overrides everything.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      pipe_load  = 1'b0;
      tile_inc   = 1'b0;
      layer_inc  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !layer_busy && !abort) begin
               accept     = 1'b1;
               state_next = ISSUE_LOAD;
            end
         end
         ISSUE_LOAD: begin
            pipe_load  = 1'b1;
            state_next = WAIT_LOAD;
         end
         WAIT_LOAD: begin
            if (pipe_empty)
               state_next = NEXT_TILE;
         end
         NEXT_TILE: begin
            tile_inc   = 1'b1;
            state_next = tile_last ? ISSUE_LAYER : ISSUE_LOAD;
         end
         ISSUE_LAYER: begin
            state_next = WAIT_LAY_ON;
         end
         WAIT_LAY_ON: begin
            if (layer_busy)
               state_next = WAIT_LAY_OFF;
         end
         WAIT_LAY_OFF: begin
            if (!layer_busy)
               state_next = NEXT_LAYER;
         end
         NEXT_LAYER: begin
            if (layer_last) begin
               state_next = DONE;
            end else begin
               layer_inc  = 1'b1;
               state_next = ISSUE_LOAD;
            end
         end
         DONE:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
`ifdef SEQ_TIMEOUT_EN
      if (wd_expired && (state_next == state))
         state_next = ERR;
`endif
      if (abort_hit) begin
         state_next = IDLE;
         pipe_load  = 1'b0;
         tile_inc   = 1'b0;
         layer_inc  = 1'b0;
      end
   end

   // Mode encoding for the state about to be entered.
   always_comb begin
      mode_next = MODE_IDLE;
      case (state_next)
         ISSUE_LOAD, WAIT_LOAD, NEXT_TILE:                   mode_next = MODE_LOAD;
         ISSUE_LAYER, WAIT_LAY_ON, WAIT_LAY_OFF, NEXT_LAYER: mode_next = MODE_LAYER;
         default:                                            mode_next = MODE_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Tile and layer counters, cleared on an accepted start or an abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tile_idx  <= '0;
         layer_idx <= '0;
      end else if (accept || abort_hit) begin
         tile_idx  <= '0;
         layer_idx <= '0;
      end else begin
         if (tile_inc)
            tile_idx <= tile_last ? '0 : tile_idx + 1'b1;
         if (layer_inc)
            layer_idx <= layer_idx + 1'b1;
      end
   end

   // Registered control outputs decoded from the upcoming state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode        <= MODE_IDLE;
         start_load  <= 1'b0;
         start_layer <= 1'b0;
         next_tile   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         mode        <= mode_next;
         start_load  <= (state_next == ISSUE_LOAD);
         start_layer <= (state_next == ISSUE_LAYER);
         next_tile   <= (state_next == NEXT_TILE);
         busy        <= (state_next != IDLE);
         done        <= (state_next == DONE);
      end
   end

`ifdef SEQ_TIMEOUT_EN
   // Watchdog counts cycles spent in one wait state; any state change clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wd <= '0;
      else if ((state_next != state) || !in_wait)
         wd <= '0;
      else
         wd <= wd + 1'b1;
   end

   // Sticky fault flag, released only by the next accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err <= 1'b0;
      else if (accept)
         err <= 1'b0;
      else if (state_next == ERR)
         err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Directed self-checking bench for systolic_tile_sequencer (N=8, TILE=4,
// NUM_LAYERS=2, PIPE_DEPTH=4, TOK_LEN=2, TMO_CYC=16). The watchdog scenario
// is selected by SEQ_TIMEOUT_EN, matching the RTL build.
module tb_systolic_tile_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic       load_ready;
   logic       layer_busy;
   logic [2:0] mode;
   logic       start_load;
   logic       start_layer;
   logic       next_tile;
   logic [0:0] tile_idx;
   logic [0:0] layer_idx;
   logic [3:0] valid_ctrl;
   logic       busy;
   logic       done;
   logic       err;

   int checks   = 0;
   int failures = 0;

   systolic_tile_sequencer #(
      .N(8), .TILE(4), .NUM_LAYERS(2), .PIPE_DEPTH(4), .TOK_LEN(2), .TMO_CYC(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .load_ready(load_ready), .layer_busy(layer_busy),
      .mode(mode), .start_load(start_load), .start_layer(start_layer),
      .next_tile(next_tile), .tile_idx(tile_idx), .layer_idx(layer_idx),
      .valid_ctrl(valid_ctrl), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Run cycles until start_layer is observed or the budget runs out.
   task automatic wait_start_layer(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         step();
         if (start_layer) seen = 1'b1;
      end
   endtask

   // Cancel whatever is running and return to IDLE.
   task automatic leave_idle();
      abort = 1'b1;
      step();
      abort = 1'b0;
      layer_busy = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if ({mode, start_load, start_layer, next_tile, tile_idx, layer_idx, valid_ctrl, busy, done, err} !== 15'd0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got mode=%0d busy=%b vc=%b err=%b, expected all zero", mode, busy, valid_ctrl, err);
      end
      @(negedge clk);
      rst = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_idle: busy got %b expected 0", busy);
      end
   endtask

   task automatic test_start_filter();
      abort = 1'b1;
      start = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0 || start_load !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_start_idle: busy=%b start_load=%b expected 0/0", busy, start_load);
      end
      abort = 1'b0;
      start = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_start_dropped: busy got %b expected 0", busy);
      end
   endtask

   task automatic test_single_tile();
      logic [3:0] exp_vc [1:9];
      logic [9:0] exp_nt;
      exp_vc = '{4'h0, 4'h1, 4'h3, 4'h6, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0};
      exp_nt = 10'b01_0000_0000;
      load_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (start_load !== 1'b1 || mode !== 3'd1 || tile_idx !== 1'b0) begin
         failures++;
         $display("[TB] FAIL tile_issue: start_load=%b mode=%0d tile=%0d expected 1/1/0", start_load, mode, tile_idx);
      end
      for (int i = 1; i <= 9; i++) begin
         step();
         checks++;
         if (valid_ctrl !== exp_vc[i]) begin
            failures++;
            $display("[TB] FAIL tile_taps[%0d]: got %b expected %b", i, valid_ctrl, exp_vc[i]);
         end
         checks++;
         if (next_tile !== exp_nt[i]) begin
            failures++;
            $display("[TB] FAIL tile_next[%0d]: got %b expected %b", i, next_tile, exp_nt[i]);
         end
      end
      checks++;
      if (start_load !== 1'b1 || tile_idx !== 1'b1) begin
         failures++;
         $display("[TB] FAIL tile_second: start_load=%b tile=%0d expected 1/1", start_load, tile_idx);
      end
      leave_idle();
      checks++;
      if (busy !== 1'b0 || valid_ctrl !== 4'h0) begin
         failures++;
         $display("[TB] FAIL tile_abort: busy=%b vc=%b expected 0/0000", busy, valid_ctrl);
      end
   endtask

   task automatic test_load_stall();
      logic [11:0] lr_tab;
      logic [12:0] exp_t0;
      int ones;
      int nt_at;
      lr_tab = 12'b1111_1110_0011;
      exp_t0 = 13'h0044;
      ones   = 0;
      nt_at  = -1;
      load_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         load_ready = lr_tab[i];
         step();
         if (valid_ctrl[0]) ones++;
         if (next_tile && nt_at < 0) nt_at = i + 1;
         checks++;
         if (valid_ctrl[0] !== exp_t0[i+1]) begin
            failures++;
            $display("[TB] FAIL stall_tap0[%0d]: got %b expected %b", i + 1, valid_ctrl[0], exp_t0[i+1]);
         end
      end
      checks++;
      if (ones != 2) begin
         failures++;
         $display("[TB] FAIL stall_token_count: got %0d expected 2", ones);
      end
      checks++;
      if (nt_at != 11) begin
         failures++;
         $display("[TB] FAIL stall_next_tile_cycle: got %0d expected 11", nt_at);
      end
      load_ready = 1'b1;
      leave_idle();
   endtask

   task automatic test_full_run();
      int sl_cnt, nt_cnt, sy_cnt, done_cnt, busy_left, after_done;
      logic [0:0] tiles [0:7];
      bit finished;
      sl_cnt = 0; nt_cnt = 0; sy_cnt = 0; done_cnt = 0; busy_left = 0; after_done = 0;
      finished = 1'b0;
      load_ready = 1'b1;
      layer_busy = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
         if (start_load) begin
            if (sl_cnt < 8) tiles[sl_cnt] = tile_idx;
            sl_cnt++;
         end
         if (next_tile) nt_cnt++;
         if (start_layer) begin
            checks++;
            if (layer_idx !== sy_cnt[0] || mode !== 3'd2) begin
               failures++;
               $display("[TB] FAIL run_layer_issue[%0d]: layer=%0d mode=%0d expected %0d/2", sy_cnt, layer_idx, mode, sy_cnt);
            end
            sy_cnt++;
            busy_left = 5;
         end
         if (done) done_cnt++;
         if (done_cnt > 0) after_done++;
         if (after_done > 3) finished = 1'b1;
         layer_busy = (busy_left > 0);
         if (busy_left > 0) busy_left--;
         if (!finished) step();
      end
      checks++;
      if (!finished) begin
         failures++;
         $display("[TB] FAIL run_timeout: done not seen within 300 cycles");
      end
      checks++;
      if (sl_cnt != 4 || nt_cnt != 4) begin
         failures++;
         $display("[TB] FAIL run_tile_pulses: start_load=%0d next_tile=%0d expected 4/4", sl_cnt, nt_cnt);
      end
      checks++;
      if (sy_cnt != 2 || done_cnt != 1) begin
         failures++;
         $display("[TB] FAIL run_layer_done: start_layer=%0d done=%0d expected 2/1", sy_cnt, done_cnt);
      end
      if (sl_cnt == 4) begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (tiles[i] !== 1'(i % 2)) begin
               failures++;
               $display("[TB] FAIL run_tile_seq[%0d]: got %0d expected %0d", i, tiles[i], i % 2);
            end
         end
      end
      checks++;
      if (busy !== 1'b0 || mode !== 3'd0) begin
         failures++;
         $display("[TB] FAIL run_end_idle: busy=%b mode=%0d expected 0/0", busy, mode);
      end
   endtask

   task automatic test_abort_lay_off();
      bit seen;
      bit saw_bad;
      load_ready = 1'b1;
      layer_busy = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_start_layer(seen);
      layer_busy = 1'b1;
      step();
      step();
      layer_busy = 1'b0;
      if (seen) wait_start_layer(seen);
      checks++;
      if (!seen || layer_idx !== 1'b1) begin
         failures++;
         $display("[TB] FAIL abort_second_layer: seen=%b layer=%0d expected 1/1", seen, layer_idx);
      end
      layer_busy = 1'b1;
      step();
      step();
      step();
      checks++;
      if (mode !== 3'd2 || busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL abort_pre: mode=%0d busy=%b expected 2/1", mode, busy);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || mode !== 3'd0 || valid_ctrl !== 4'h0 || done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_idle: busy=%b mode=%0d vc=%b done=%b expected 0/0/0000/0", busy, mode, valid_ctrl, done);
      end
      layer_busy = 1'b0;
      saw_bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (done || busy) saw_bad = 1'b1;
      end
      checks++;
      if (saw_bad !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_quiet: got activity=%b expected 0", saw_bad);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (start_load !== 1'b1 || tile_idx !== 1'b0 || layer_idx !== 1'b0 || mode !== 3'd1) begin
         failures++;
         $display("[TB] FAIL abort_restart: sl=%b tile=%0d layer=%0d mode=%0d expected 1/0/0/1", start_load, tile_idx, layer_idx, mode);
      end
      step();
      step();
      checks++;
      if (valid_ctrl !== 4'h1) begin
         failures++;
         $display("[TB] FAIL abort_restart_taps: got %b expected 0001", valid_ctrl);
      end
      leave_idle();
   endtask

   task automatic test_reset_mid();
      load_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      checks++;
      if (valid_ctrl !== 4'h3) begin
         failures++;
         $display("[TB] FAIL rstmid_pre: vc got %b expected 0011", valid_ctrl);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({mode, start_load, start_layer, next_tile, tile_idx, layer_idx, valid_ctrl, busy, done, err} !== 15'd0) begin
         failures++;
         $display("[TB] FAIL rstmid_async: mode=%0d vc=%b busy=%b expected all zero", mode, valid_ctrl, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      step();
      layer_busy = 1'b1;
      start = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0 || start_load !== 1'b0) begin
         failures++;
         $display("[TB] FAIL start_while_layer_busy: busy=%b sl=%b expected 0/0", busy, start_load);
      end
      start = 1'b0;
      layer_busy = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL start_dropped: busy got %b expected 0", busy);
      end
   endtask

`ifdef SEQ_TIMEOUT_EN
   task automatic test_watchdog();
      bit seen;
      bit early;
      load_ready = 1'b1;
      layer_busy = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_start_layer(seen);
      checks++;
      if (!seen) begin
         failures++;
         $display("[TB] FAIL wd_start_layer: seen got 0 expected 1");
      end
      step();
      early = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         step();
         if (err) early = 1'b1;
      end
      checks++;
      if (early !== 1'b0) begin
         failures++;
         $display("[TB] FAIL wd_early: err seen before limit, got 1 expected 0");
      end
      step();
      checks++;
      if (err !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL wd_fire: err=%b busy=%b expected 1/1", err, busy);
      end
      step();
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL wd_idle: err=%b busy=%b done=%b expected 1/0/0", err, busy, done);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (err !== 1'b0 || start_load !== 1'b1) begin
         failures++;
         $display("[TB] FAIL wd_clear: err=%b sl=%b expected 0/1", err, start_load);
      end
      leave_idle();
   endtask
`else
   task automatic test_watchdog();
      bit seen;
      load_ready = 1'b1;
      layer_busy = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_start_layer(seen);
      for (int k = 0; k < 40; k++) step();
      checks++;
      if (!seen || err !== 1'b0 || busy !== 1'b1 || mode !== 3'd2) begin
         failures++;
         $display("[TB] FAIL no_wd_wait: seen=%b err=%b busy=%b mode=%0d expected 1/0/1/2", seen, err, busy, mode);
      end
      leave_idle();
   endtask
`endif

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      load_ready = 1'b0;
      layer_busy = 1'b0;
      test_reset();
      test_start_filter();
      test_single_tile();
      test_load_stall();
      test_full_run();
      test_abort_lay_off();
      test_reset_mid();
      test_watchdog();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
